// File: rtl/sbldc_gate_deadtime.sv
// sbldc_gate_deadtime
//   Final gate-drive stage for four 3-phase BLDC motors (12 half-bridge legs).
//   Resynchronises the commutation pattern into clk, inserts a programmable
//   dead time between one switch of a leg turning off and either switch
//   turning on again, and suppresses shoot-through requests (H=L=1).
//
//   Optional feature: define SBLDC_GATE_PWM_EN to add a duty input and an
//   8-bit free-running PWM counter that chops high-side requests.
//
// Ports
//   clk        : system clock (50 MHz)
//   reset      : asynchronous active-low reset
//   PT_in      : commutation request, leg j = 3m+k, [2j+1]=high, [2j]=low
//   enable     : 1 = drive gates, 0 = request all legs off
//   fault_clr  : single-cycle pulse, clears sticky fault flags
//   duty       : (SBLDC_GATE_PWM_EN only) high-side duty, 0..255 of 256
//   GD         : gate drive, same bit mapping as PT_in
//   fault      : sticky per-motor shoot-through request flag
//   busy       : 1 while any leg is in its dead time
module sbldc_gate_deadtime #(
  parameter int unsigned DEADTIME = 50,
  parameter int unsigned CW       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] PT_in,
  input  logic        enable,
  input  logic        fault_clr,
`ifdef SBLDC_GATE_PWM_EN
  input  logic [7:0]  duty,
`endif
  output logic [23:0] GD,
  output logic [3:0]  fault,
  output logic        busy
);

  localparam int unsigned   NLEG    = 12;
  localparam logic [CW-1:0] DT_LOAD = CW'(DEADTIME - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_HI_ON = 2'd1,
    S_LO_ON = 2'd2,
    S_DEAD  = 2'd3
  } leg_state_t;

  logic [23:0]   r_s1;
  logic [23:0]   r_s2;
  leg_state_t    r_state [NLEG];
  logic [CW-1:0] r_cnt   [NLEG];
  logic [23:0]   r_gd;
  logic [3:0]    r_fault;
  logic          r_busy;

  logic            w_hi_ok;
  logic [NLEG-1:0] w_req_hi;
  logic [NLEG-1:0] w_req_lo;
  logic [NLEG-1:0] w_bad;
  logic [3:0]      w_fault_set;
  leg_state_t      w_nxt_state [NLEG];
  logic [CW-1:0]   w_nxt_cnt   [NLEG];
  logic [23:0]     w_nxt_gd;
  logic            w_nxt_busy;

`ifdef SBLDC_GATE_PWM_EN
  logic [7:0] r_pwm_cnt;
  logic [7:0] r_duty;

  // duty is only taken at the end of a PWM period so a period is never split
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm_cnt <= '0;
      r_duty    <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      if (r_pwm_cnt == 8'hFF) begin
        r_duty <= duty;
      end
    end
  end

  assign w_hi_ok = (r_pwm_cnt < r_duty);
`else
  assign w_hi_ok = 1'b1;
`endif

  // Request decode from the second synchronizer stage; BAD decodes to NONE.
  always_comb begin
    w_req_hi    = '0;
    w_req_lo    = '0;
    w_bad       = '0;
    w_fault_set = '0;
    for (int unsigned j = 0; j < NLEG; j++) begin
      w_bad[j]    = r_s2[2*j+1] & r_s2[2*j];
      w_req_hi[j] = enable & r_s2[2*j+1] & ~r_s2[2*j] & w_hi_ok;
      w_req_lo[j] = enable & r_s2[2*j] & ~r_s2[2*j+1];
    end
    for (int unsigned m = 0; m < 4; m++) begin
      w_fault_set[m] = enable & (|w_bad[3*m +: 3]);
    end
  end

  // Per-leg next state. Gate and busy outputs are derived from the next
  // state so they register on the same edge as the state itself.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_gd    = '0;
    w_nxt_busy  = 1'b0;
    for (int unsigned j = 0; j < NLEG; j++) begin
      case (r_state[j])
        S_OFF: begin
          if (w_req_hi[j]) begin
            w_nxt_state[j] = S_HI_ON;
          end else if (w_req_lo[j]) begin
            w_nxt_state[j] = S_LO_ON;
          end
        end
        S_HI_ON: begin
          if (!w_req_hi[j]) begin
            w_nxt_state[j] = S_DEAD;
            w_nxt_cnt[j]   = DT_LOAD;
          end
        end
        S_LO_ON: begin
          if (!w_req_lo[j]) begin
            w_nxt_state[j] = S_DEAD;
            w_nxt_cnt[j]   = DT_LOAD;
          end
        end
        S_DEAD: begin
          // Full dead time always runs, even if the old side is requested again
          if (r_cnt[j] == '0) begin
            w_nxt_state[j] = S_OFF;
          end else begin
            w_nxt_cnt[j] = r_cnt[j] - 1'b1;
          end
        end
        default: begin
          w_nxt_state[j] = S_OFF;
          w_nxt_cnt[j]   = '0;
        end
      endcase
      w_nxt_gd[2*j+1] = (w_nxt_state[j] == S_HI_ON);
      w_nxt_gd[2*j]   = (w_nxt_state[j] == S_LO_ON);
      w_nxt_busy      = w_nxt_busy | (w_nxt_state[j] == S_DEAD);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_gd    <= '0;
      r_fault <= '0;
      r_busy  <= 1'b0;
      for (int unsigned j = 0; j < NLEG; j++) begin
        r_state[j] <= S_OFF;
        r_cnt[j]   <= '0;
      end
    end else begin
      r_s1 <= PT_in;
      r_s2 <= r_s1;
      for (int unsigned j = 0; j < NLEG; j++) begin
        r_state[j] <= w_nxt_state[j];
        r_cnt[j]   <= w_nxt_cnt[j];
      end
      r_gd    <= w_nxt_gd;
      r_busy  <= w_nxt_busy;
      // set has priority over a simultaneous clear
      r_fault <= (r_fault & ~{4{fault_clr}}) | w_fault_set;
    end
  end

  assign GD    = r_gd;
  assign fault = r_fault;
  assign busy  = r_busy;

endmodule
